reset_req_gen: RTL and testbench
================================

RESET_REQ_GEN -- requirements
Module: reset_req_gen

Interface
REQ-001 SHALL have parameter DEB_CNT, default 50000, meaning cycles the synchronized button must hold a new level before it is accepted.
REQ-002 SHALL have parameter PULSE_LEN, default 16, meaning width in cycles of the rst_req pulse (range 1..65535).
REQ-003 SHALL have parameter HOLDOFF, default 1000, meaning cycles after the pulse during which new requests are ignored.
REQ-004 SHALL have parameter WDT_TIMEOUT, default 1000000, meaning watchdog expiry in cycles (24-bit).
REQ-005 SHALL have port clk  input  1  design clock.
REQ-006 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port btn  input  1  raw board button, asynchronous, active-high.
REQ-008 SHALL have port sw_req  input  1  software reset request, single-cycle pulse, synchronous to clk.
REQ-009 SHALL have port wdt_en  input  1  watchdog enable level.
REQ-010 SHALL have port wdt_kick  input  1  watchdog service pulse.
REQ-011 SHALL have port rst_req  output  1  active-high reset request, drives the clock/reset generator's board-reset input.
REQ-012 SHALL have port rst_cause  output  2  last accepted cause: 0 none, 1 button, 2 watchdog, 3 software.
REQ-013 SHALL have port busy  output  1  high while not in IDLE.

Function
REQ-014 SHALL pass btn through a 2-flop synchronizer before any other use.
REQ-015 SHALL keep a debounced level btn_db; counter clears while synced btn equals btn_db, increments otherwise; on reaching DEB_CNT btn_db toggles and counter clears.
REQ-016 SHALL generate a button event on the 0->1 transition of btn_db only.
REQ-017 SHALL run a 24-bit watchdog counter: cleared when wdt_en low, wdt_kick high, or state not IDLE; else increments; at WDT_TIMEOUT-1 it raises a watchdog event and clears.
REQ-018 SHALL implement FSM IDLE -> PULSE -> HOLDOFF -> IDLE.
REQ-019 IDLE: on any event, go to PULSE next cycle, load pulse counter, register cause; rst_req high from the cycle after the event.
REQ-020 PULSE: rst_req high exactly PULSE_LEN cycles, then HOLDOFF.
REQ-021 HOLDOFF: rst_req low; leave to IDLE only after HOLDOFF cycles elapsed AND btn_db low; remain otherwise.
REQ-022 Simultaneous events SHALL resolve by priority button > watchdog > software; only the winner is recorded.
REQ-023 Events arriving in PULSE or HOLDOFF SHALL be discarded, not queued; sw_req is not stored.
REQ-024 rst_cause SHALL hold its value until the next accepted event (survives the requested reset, which does not drive RESET).
REQ-025 rst_req SHALL be driven directly from a flop (glitch-free).

Reset
REQ-026 RESET assertion SHALL asynchronously force: state IDLE, rst_req 0, busy 0, rst_cause 0, btn_db 0, synchronizer flops 0, all counters 0.
REQ-027 RESET asserted mid-PULSE SHALL drop rst_req immediately; no pulse resumes after release.
REQ-028 First event SHALL be accepted no earlier than the first clk edge after RESET deasserts.

Configuration
REQ-029 Macro RESET_REQ_WATCHDOG_EN defined: watchdog per REQ-017 present.
REQ-030 Macro RESET_REQ_WATCHDOG_EN undefined: watchdog counter absent, wdt_en/wdt_kick ignored, cause 2 never produced; ports retained.

Verification (DEB_CNT=4, PULSE_LEN=8, HOLDOFF=4, WDT_TIMEOUT=20)
REQ-031 sw_req pulse at cycle 10 -> rst_req high cycles 11..18, busy high 11..22, rst_cause=3, IDLE at 23.
REQ-032 btn bounced 1/0 every 2 cycles for 20 cycles, then held high -> no event while bouncing; single pulse, rst_cause=1; held btn keeps busy high until released plus 4-cycle debounce.
REQ-033 wdt_en=1, no kick -> pulse at cycle ~21 after enable, rst_cause=2; kick every 10 cycles -> no pulse for 200 cycles.
REQ-034 sw_req and btn event same cycle -> one pulse, rst_cause=1; sw_req during HOLDOFF -> ignored, no second pulse.
REQ-035 RESET asserted at 4th cycle of pulse -> rst_req 0 same time step, rst_cause 0, no pulse after release.
REQ-036 Build without RESET_REQ_WATCHDOG_EN, wdt_en=1 for 100 cycles -> rst_req stays 0.

Source files
------------

// File: rtl/reset_req_gen.sv
// -----------------------------------------------------------------------------
// reset_req_gen
//
// Purpose:
//   Collects reset requests from three sources and turns the winning request
//   into one clean, fixed-width, flop-driven reset request pulse:
//     - board button (asynchronous; synchronized and debounced here)
//     - hardware watchdog (optional, see RESET_REQ_WATCHDOG_EN)
//     - software request (single-cycle pulse, synchronous to clk)
//   After each pulse a hold-off window ignores further requests, so one
//   press or one timeout produces exactly one pulse.
//
// Ports:
//   clk        in   design clock
//   RESET      in   asynchronous, active-high reset
//   btn        in   raw board button, asynchronous, active-high
//   sw_req     in   software reset request, single-cycle pulse
//   wdt_en     in   watchdog enable level
//   wdt_kick   in   watchdog service pulse
//   rst_req    out  active-high reset request (registered)
//   rst_cause  out  last accepted cause: 0 none, 1 button, 2 watchdog, 3 sw
//   busy       out  high while the request FSM is not idle
//
// Build option:
//   RESET_REQ_WATCHDOG_EN  defined   -> watchdog counter is built in
//                          undefined -> no watchdog; wdt_en/wdt_kick ignored
// -----------------------------------------------------------------------------
module reset_req_gen #(
  parameter int DEB_CNT     = 50000,
  parameter int PULSE_LEN   = 16,
  parameter int HOLDOFF     = 1000,
  parameter int WDT_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       btn,
  input  logic       sw_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       rst_req,
  output logic [1:0] rst_cause,
  output logic       busy
);

  // Debounce counter only ever holds 0..DEB_CNT-1.
  localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  // One shared counter times both the pulse and the hold-off window.
  localparam int CNT_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [1:0]         r_cause;
  logic [1:0]         w_cause_next;
  logic               r_rst_req;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_btn_db;
  logic [DEB_W-1:0]   r_deb_cnt;
  logic               w_deb_hit;
  logic               w_btn_event;
  logic               w_wdt_event;

  // ---------------------------------------------------------------------------
  // Button: 2-flop synchronizer, then debounce on the synchronized level.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // The new level must differ from btn_db for DEB_CNT consecutive cycles.
  assign w_deb_hit = (r_sync2 != r_btn_db) && (r_deb_cnt == DEB_LAST);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_btn_db  <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_btn_db) begin
      r_deb_cnt <= '0;
    end else if (w_deb_hit) begin
      r_btn_db  <= ~r_btn_db;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  // Event coincides with the edge at which btn_db goes 0 -> 1.
  assign w_btn_event = w_deb_hit & ~r_btn_db;

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef RESET_REQ_WATCHDOG_EN
  localparam logic [23:0] WDT_LAST = 24'(WDT_TIMEOUT - 1);
  logic [23:0] r_wdt_cnt;
  logic        w_wdt_hold;

  // Counter is parked while disabled, kicked, or a request is in progress.
  assign w_wdt_hold  = ~wdt_en | wdt_kick | (r_state != ST_IDLE);
  assign w_wdt_event = ~w_wdt_hold & (r_wdt_cnt == WDT_LAST);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_wdt_cnt <= '0;
    end else if (w_wdt_hold || (r_wdt_cnt == WDT_LAST)) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + 24'd1;
    end
  end
`else
  logic w_unused_wdt;
  assign w_unused_wdt = wdt_en ^ wdt_kick;
  assign w_wdt_event  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Request FSM: IDLE -> PULSE -> HOLD -> IDLE
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cause_next = r_cause;
    case (r_state)
      ST_IDLE: begin
        // Fixed priority: button > watchdog > software.
        if (w_btn_event) begin
          w_state_next = ST_PULSE;
          w_cnt_next   = PULSE_LAST;
          w_cause_next = 2'd1;
        end else if (w_wdt_event) begin
          w_state_next = ST_PULSE;
          w_cnt_next   = PULSE_LAST;
          w_cause_next = 2'd2;
        end else if (sw_req) begin
          w_state_next = ST_PULSE;
          w_cnt_next   = PULSE_LAST;
          w_cause_next = 2'd3;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        // Counter saturates; a held button keeps us here past the window.
        if (r_cnt == HOLD_LAST) begin
          if (!r_btn_db) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cause   <= 2'd0;
      r_rst_req <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_cause   <= w_cause_next;
      // Registered so the request line never glitches.
      r_rst_req <= (w_state_next == ST_PULSE);
    end
  end

  assign rst_req   = r_rst_req;
  assign rst_cause = r_cause;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reset_req_gen.sv
// -----------------------------------------------------------------------------
// tb_reset_req_gen
//
// Bench for reset_req_gen with DEB_CNT=4, PULSE_LEN=8, HOLDOFF=4,
// WDT_TIMEOUT=20. Software-request timelines come from a vector table and
// are checked cycle by cycle through an expectation queue; button,
// watchdog and reset corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_reset_req_gen;

  localparam int P_DEB   = 4;
  localparam int P_PULSE = 8;
  localparam int P_HOLD  = 4;
  localparam int P_WDT   = 20;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       btn = 1'b0;
  logic       sw_req = 1'b0;
  logic       wdt_en = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       rst_req;
  logic [1:0] rst_cause;
  logic       busy;

  always #5 clk = ~clk;

  reset_req_gen #(
    .DEB_CNT    (P_DEB),
    .PULSE_LEN  (P_PULSE),
    .HOLDOFF    (P_HOLD),
    .WDT_TIMEOUT(P_WDT)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .btn      (btn),
    .sw_req   (sw_req),
    .wdt_en   (wdt_en),
    .wdt_kick (wdt_kick),
    .rst_req  (rst_req),
    .rst_cause(rst_cause),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  // Per-cycle expectation {rst_req, busy, rst_cause}.
  typedef struct packed {
    logic       rq;
    logic       bz;
    logic [1:0] cause;
  } exp_t;
  exp_t       exp_q[$];
  logic [1:0] exp_cause = 2'd0;

  // Vector: idle cycles, wdt_en level, sw_req pulse, and whether it is accepted.
  typedef struct packed {
    logic [7:0] gap;
    logic       we;
    logic       sw;
    logic       accept;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected timeline of one accepted request: PULSE_LEN high, HOLDOFF busy.
  task automatic push_pulse(input logic [1:0] cause);
    repeat (P_PULSE) exp_q.push_back({1'b1, 1'b1, cause});
    repeat (P_HOLD)  exp_q.push_back({1'b0, 1'b1, cause});
    exp_cause = cause;
  endtask

  // Drive one cycle of inputs (from a negedge), then sample at the next negedge.
  task automatic tick(input logic sw, input logic b, input logic we, input logic wk,
                      input logic sb);
    exp_t e;
    sw_req   = sw;
    btn      = b;
    wdt_en   = we;
    wdt_kick = wk;
    @(posedge clk);
    @(negedge clk);
    sw_req   = 1'b0;
    wdt_kick = 1'b0;
    if (sb) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = {1'b0, 1'b0, exp_cause};
      check("sb_cycle", {28'd0, rst_req, busy, rst_cause}, {28'd0, e});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    int   w;
    int   rises;
    logic found;
    logic prev;

    // Table: sw at cycle 10, then probes of HOLD/IDLE/PULSE boundaries.
    vecs.push_back({8'd10, 1'b0, 1'b1, 1'b1}); // first request, cycle 10
    vecs.push_back({8'd8,  1'b0, 1'b1, 1'b0}); // first HOLD cycle: ignored
    vecs.push_back({8'd3,  1'b0, 1'b1, 1'b1}); // first IDLE cycle: accepted
    vecs.push_back({8'd11, 1'b0, 1'b1, 1'b0}); // last HOLD cycle: ignored
    vecs.push_back({8'd0,  1'b0, 1'b1, 1'b1}); // next cycle is IDLE: accepted
    vecs.push_back({8'd3,  1'b0, 1'b1, 1'b0}); // mid-PULSE: ignored
    vecs.push_back({8'd30, 1'b0, 1'b0, 1'b0}); // quiet
    vecs.push_back({8'd0,  1'b0, 1'b1, 1'b1}); // accepted again
`ifndef RESET_REQ_WATCHDOG_EN
    vecs.push_back({8'd100, 1'b1, 1'b0, 1'b0}); // no watchdog in this build
    vecs.push_back({8'd0,   1'b1, 1'b1, 1'b1});
`endif

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("reset_rst_req", rst_req, 0);
    check("reset_busy", busy, 0);
    check("reset_cause", rst_cause, 0);
    RESET = 1'b0;

    foreach (vecs[k]) begin
      repeat (int'(vecs[k].gap)) tick(1'b0, 1'b0, vecs[k].we, 1'b0, 1'b1);
      if (vecs[k].sw) begin
        if (vecs[k].accept) push_pulse(2'd3);
        tick(1'b1, 1'b0, vecs[k].we, 1'b0, 1'b1);
      end
    end
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Button bounce: level changes every 2 cycles never survives debounce.
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, ((i / 2) % 2) == 0, 1'b0, 1'b0, 1'b0);
      check("bounce_no_req", rst_req, 0);
    end
    check("bounce_busy", busy, 0);

    // Held high: exactly one pulse, cause button.
    n = 0;
    found = 1'b0;
    while (!found && n < 12) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n++;
      if (rst_req) found = 1'b1;
    end
    check("btn_rise", found, 1);
    check("btn_cause", rst_cause, 1);
    w = 1;
    while (rst_req && w < 20) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (rst_req) w++;
    end
    check("btn_width", w, P_PULSE);
    rises = 0;
    repeat (30) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (rst_req) rises++;
    end
    check("btn_hold_no_repulse", rises, 0);
    check("btn_hold_busy", busy, 1);

    // Release: 2 sync flops + DEB_CNT debounce keep busy high a while.
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("btn_release_busy", busy, 1);
    n = 0;
    while (busy && n < 12) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("btn_release_idle", busy, 0);
    check("btn_cause_kept", rst_cause, 1);

    // sw_req on the same cycle as the button event: button wins.
    // Event edge = 2 synchronizer edges + DEB_CNT debounce edges.
    for (int i = 0; i < 2 + P_DEB - 1; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("simul_pre", rst_req, 0);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("simul_req", rst_req, 1);
    check("simul_cause", rst_cause, 1);
    rises = 0;
    prev = rst_req;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (rst_req && !prev) rises++;
      prev = rst_req;
    end
    n = 0;
    while ((busy || n < 2) && n < 20) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (rst_req && !prev) rises++;
      prev = rst_req;
      n++;
    end
    check("simul_single_pulse", rises, 0);
    check("simul_idle", busy, 0);
    exp_cause = 2'd1;

`ifdef RESET_REQ_WATCHDOG_EN
    // Watchdog enabled with no kick: expires after about WDT_TIMEOUT cycles.
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n++;
      if (rst_req) found = 1'b1;
    end
    check("wdt_rise", found, 1);
    check("wdt_timing", (n >= P_WDT - 2) && (n <= P_WDT + 4), 1);
    check("wdt_cause", rst_cause, 2);
    // Kicked every 10 cycles: no further pulse.
    rises = 0;
    prev = rst_req;
    for (int i = 0; i < 220; i++) begin
      tick(1'b0, 1'b0, 1'b1, (i % 10) == 9, 1'b0);
      if (rst_req && !prev) rises++;
      prev = rst_req;
    end
    check("wdt_kicked_quiet", rises, 0);
    check("wdt_kicked_idle", busy, 0);
    exp_cause = 2'd2;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // RESET during the 4th pulse cycle: output drops in the same time step.
    push_pulse(2'd3);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    RESET = 1'b1;
    #1;
    check("rst_mid_req", rst_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cause", rst_cause, 0);
    exp_q.delete();
    exp_cause = 2'd0;
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
